// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests to
// instruction memory and buffers returned words with their PCs for decode.
module fetch_queue_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              QDEPTH       = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [31:0]     io_imem_resp_data,
  input  logic            io_jal_en,
  input  logic            io_jalr_en,
  input  logic [XLEN-1:0] io_br_pc,
  input  logic [XLEN-1:0] io_imm,
  input  logic [XLEN-1:0] io_rs1,
  input  logic            io_stall_en,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_pc,
  output logic [31:0]     io_out_inst,
  output logic            io_misaligned
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]   outstanding, drop_cnt, wr_ptr, rd_ptr;
  logic [XLEN-1:0] pc_q   [QDEPTH];
  logic [31:0]     inst_q [QDEPTH];
  logic            misaligned_r;

  logic            redirect, req_fire, enq, deq, credit_ok;
  logic [XLEN-1:0] jal_tgt, jalr_sum, target;
  logic [CW-1:0]   occupancy, outstanding_nxt;

  assign redirect  = io_jal_en | io_jalr_en;
  assign jal_tgt   = io_br_pc + io_imm;
  assign jalr_sum  = io_rs1 + io_imm;
  assign target    = io_jal_en ? jal_tgt : {jalr_sum[XLEN-1:1], 1'b0};
  assign occupancy = wr_ptr - rd_ptr;

  // Outstanding requests plus buffered entries never exceed the queue, so an
  // enqueue always finds a free slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, occupancy}) < (CW+1)'(QDEPTH);

  // Gated by reset so no request is presented while the block is held in reset.
  assign io_imem_req_valid = reset & (state == RUN) & ~io_stall_en & credit_ok;
  assign io_imem_req_addr  = fetch_pc;
  assign req_fire          = io_imem_req_valid & io_imem_req_ready;

  assign enq = io_imem_resp_valid & (drop_cnt == '0) & ~redirect & (state == RUN);
  assign io_out_valid = (occupancy != '0) & ~redirect;
  assign deq          = io_out_valid & io_out_ready;
  assign io_out_pc    = pc_q[rd_ptr[AW-1:0]];
  assign io_out_inst  = inst_q[rd_ptr[AW-1:0]];
  assign io_misaligned = misaligned_r;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(io_imem_resp_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      fetch_pc     <= RESET_VECTOR;
      resp_pc      <= RESET_VECTOR;
      outstanding  <= '0;
      drop_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      misaligned_r <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        // Every request still in flight, including one accepted now, is stale.
        drop_cnt <= outstanding_nxt;
        fetch_pc <= target;
        resp_pc  <= target;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        if (target[1]) begin
          state        <= HALT;
          misaligned_r <= 1'b1;
        end
      end else begin
        if (io_imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (enq) begin
          pc_q[wr_ptr[AW-1:0]]   <= resp_pc;
          inst_q[wr_ptr[AW-1:0]] <= io_imem_resp_data;
          wr_ptr                 <= wr_ptr + CW'(1);
          resp_pc                <= resp_pc + XLEN'(4);
        end
        if (deq) rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit: an in-order variable-latency memory
// plus a reference of in-flight requests and the decode-visible instruction stream.
module tb_fetch_queue_unit;
  localparam int          QD = 4;
  localparam logic [31:0] RV = 32'hFFFF_FFF8;

  logic        clock, reset;
  logic        io_imem_req_valid, io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_jal_en, io_jalr_en;
  logic [31:0] io_br_pc, io_imm, io_rs1;
  logic        io_stall_en;
  logic        io_out_valid, io_out_ready;
  logic [31:0] io_out_pc, io_out_inst;
  logic        io_misaligned;

  fetch_queue_unit #(.XLEN(32), .RESET_VECTOR(RV), .QDEPTH(QD)) dut (
    .clock(clock), .reset(reset),
    .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_addr(io_imem_req_addr),
    .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_data(io_imem_resp_data),
    .io_jal_en(io_jal_en), .io_jalr_en(io_jalr_en),
    .io_br_pc(io_br_pc), .io_imm(io_imm), .io_rs1(io_rs1),
    .io_stall_en(io_stall_en),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_pc(io_out_pc), .io_out_inst(io_out_inst),
    .io_misaligned(io_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: memory in-flight list (address, due cycle, still wanted),
  // decode-visible PCs, next fetch address and halt flag.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          mq_live[$];
  logic [31:0] buf_pc[$];
  logic [31:0] exp_fetch;
  bit          halted;
  int          cyc, last_due;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9E17;
  endfunction

  task automatic idle_inputs();
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    io_jal_en = 1'b0; io_jalr_en = 1'b0;
    io_br_pc = '0; io_imm = '0; io_rs1 = '0;
    io_stall_en = 1'b0; io_out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_req_valid", io_imem_req_valid, 0);
    chk("rst_out_valid", io_out_valid, 0);
    chk("rst_misaligned", io_misaligned, 0);
    chk("rst_out_pc", io_out_pc, 0);
    chk("rst_out_inst", io_out_inst, 0);
    @(negedge clock);
    reset = 1'b1;
    mq_addr.delete(); mq_due.delete(); mq_live.delete(); buf_pc.delete();
    exp_fetch = RV; halted = 0; last_due = cyc;
  endtask

  task automatic cycle(input int p_rdy, input int p_ordy, input int p_stall,
                       input int p_redir, input int lat_max, input bit force_misal);
    bit exp_rv, exp_ov, redir, fire, rv;
    logic [31:0] tgt, sum;
    logic [11:0] r;
    int kind, due;
    @(negedge clock);
    io_imem_req_ready = ($urandom % 100) < p_rdy;
    io_out_ready      = ($urandom % 100) < p_ordy;
    io_stall_en       = ($urandom % 100) < p_stall;
    io_jal_en = 1'b0; io_jalr_en = 1'b0;
    io_br_pc = $urandom & ~32'h3;
    r = 12'($urandom);
    io_imm = {{20{r[11]}}, r[11:2], 2'b00};
    io_rs1 = $urandom & ~32'h2;
    if (force_misal) begin
      io_jalr_en = 1'b1; io_rs1 = 32'h102; io_imm = '0;
    end else if (($urandom % 100) < p_redir) begin
      kind = $urandom % 3;
      io_jal_en  = (kind != 1);
      io_jalr_en = (kind != 0);
    end
    rv = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    io_imem_resp_valid = rv;
    io_imem_resp_data  = rv ? memf(mq_addr[0]) : $urandom;
    #1;
    redir = io_jal_en | io_jalr_en;
    sum = io_rs1 + io_imm;
    tgt = io_jal_en ? io_br_pc + io_imm : (sum & ~32'h1);
    exp_rv = !halted && !io_stall_en && (mq_addr.size() + buf_pc.size() < QD);
    chk("req_valid", io_imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", io_imem_req_addr, exp_fetch);
    exp_ov = (buf_pc.size() > 0) && !redir;
    chk("out_valid", io_out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_pc", io_out_pc, buf_pc[0]);
      chk("out_inst", io_out_inst, memf(buf_pc[0]));
    end
    chk("misaligned", io_misaligned, halted);
    fire = exp_rv && io_imem_req_ready;
    @(posedge clock);
    if (exp_ov && io_out_ready) void'(buf_pc.pop_front());
    if (rv) begin
      if (mq_live[0] && !redir && !halted) buf_pc.push_back(mq_addr[0]);
      void'(mq_addr.pop_front()); void'(mq_due.pop_front()); void'(mq_live.pop_front());
    end
    if (fire) begin
      due = cyc + $urandom_range(1, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(exp_fetch); mq_due.push_back(due); mq_live.push_back(1'b1);
    end
    if (redir) begin
      foreach (mq_live[i]) mq_live[i] = 1'b0;
      buf_pc.delete();
      exp_fetch = tgt;
      if (tgt[1]) halted = 1;
    end else if (fire) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0; last_due = 0;
    reset = 1'b0;
    idle_inputs();
    apply_reset();
    // Streaming through the 32-bit wrap with single-cycle memory.
    repeat (40) cycle(100, 100, 0, 0, 1, 0);
    // Decode blocked: credits stop fetching at QDEPTH, then drain.
    repeat (20) cycle(100, 0, 0, 0, 1, 0);
    repeat (20) cycle(100, 100, 0, 0, 1, 0);
    // Stall pulse mid-stream.
    repeat (10) cycle(100, 100, 0, 0, 2, 0);
    repeat (5)  cycle(100, 100, 100, 0, 2, 0);
    repeat (20) cycle(100, 100, 0, 0, 2, 0);
    // Random mixes of backpressure, stall, redirects and latency.
    for (int ph = 0; ph < 6; ph++) begin
      int pr, po, ps, pd, lm;
      pr = $urandom_range(40, 100); po = $urandom_range(30, 100);
      ps = $urandom_range(0, 30);   pd = $urandom_range(0, 12);
      lm = $urandom_range(1, 5);
      repeat (300) cycle(pr, po, ps, pd, lm, 0);
    end
    // Misaligned JALR with requests in flight, then halted behaviour.
    repeat (6) cycle(100, 100, 0, 0, 3, 0);
    cycle(100, 100, 0, 0, 3, 1);
    repeat (30) cycle(100, 100, 0, 0, 3, 0);
    // Reset recovers from halt and restarts at the reset vector.
    apply_reset();
    repeat (40) cycle(80, 80, 10, 5, 3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch stage.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready channel; the memory returns in-order responses at any latency ≥1.
- Buffers returned instructions with their PCs in a QDEPTH-entry queue for decode.
- Handles JAL/JALR redirects with queue flush and in-flight response discard, fetch stall, and misaligned-target halt.

Parameters:
XLEN, 32, width of PC, imm, rs1 and memory address
RESET_VECTOR, 0, fetch PC after reset (XLEN bits, must be 4-aligned)
QDEPTH, 4, instruction queue entries and max outstanding-plus-buffered fetches; power of 2, ≥2

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
io_imem_req_valid  out  1  fetch request valid
io_imem_req_ready  in  1  memory accepts request
io_imem_req_addr  out  XLEN  fetch address (current fetch PC)
io_imem_resp_valid  in  1  instruction word returned (in request order)
io_imem_resp_data  in  32  instruction word
io_jal_en  in  1  JAL redirect this cycle
io_jalr_en  in  1  JALR redirect this cycle
io_br_pc  in  XLEN  PC of the jumping instruction
io_imm  in  XLEN  sign-extended immediate
io_rs1  in  XLEN  rs1 value
io_stall_en  in  1  suppress new fetch requests
io_out_valid  out  1  queue head valid
io_out_ready  in  1  decode accepts head
io_out_pc  out  XLEN  PC of head instruction
io_out_inst  out  32  head instruction
io_misaligned  out  1  sticky: redirect target not 4-aligned; fetch halted

Behaviour:
- Reset (reset=0, async):
  - fetch_pc = resp_pc = RESET_VECTOR.
  - Queue empty; outstanding = 0; drop_cnt = 0; state = RUN.
  - Outputs: io_imem_req_valid=0, io_out_valid=0, io_misaligned=0, io_out_pc=0, io_out_inst=0.
  - A mid-operation reset abandons in-flight requests; the memory side is reset together with this block.
- States:
  - RUN: normal fetching.
  - HALT: entered on a misaligned redirect; never leaves except via reset.
- Request issue:
  - io_imem_req_valid = (state==RUN) & !io_stall_en & (outstanding + occupancy < QDEPTH).
  - req_fire = valid & ready, which advances fetch_pc by 4 (mod 2^XLEN, wraps).
  - While a request is pending and no redirect occurs, io_imem_req_addr holds stable.
- Outstanding counter:
  - +1 on req_fire, -1 on resp_valid.
  - Both in the same cycle: no change.
- Live response (resp_valid & drop_cnt==0 & no redirect this cycle):
  - Enqueues {resp_pc, resp_data}; resp_pc += 4.
  - Credit rule guarantees the queue is never full on enqueue.
- Dequeue:
  - io_out_valid = queue non-empty & no redirect this cycle.
  - Pop on io_out_valid & io_out_ready.
  - Enqueue and dequeue in the same cycle both take effect.
  - The head is exposed directly from queue storage (0-cycle read).
  - Min latency from req_fire to io_out_valid: 1 cycle after resp_valid.
- Redirect (io_jal_en | io_jalr_en):
  - Target:
    - JAL: io_br_pc + io_imm.
    - JALR: (io_rs1 + io_imm) & ~1.
    - Both asserted: JAL wins.
  - Effect at next edge:
    - fetch_pc = resp_pc = target.
    - Queue flushed.
    - drop_cnt = outstanding + req_fire − resp_valid (all in-flight requests, including one accepted this cycle, are discarded).
  - Any resp_valid in the redirect cycle is discarded.
  - The redirect may withdraw an unaccepted request; the memory must tolerate the address change.
  - Redirect while drop_cnt>0 recomputes drop_cnt by the same formula.
  - target[1]=1 → io_misaligned=1 (sticky), state=HALT; queue flushed; no further requests.
  - In HALT, responses are still counted and discarded.
- Dropped response (resp_valid & drop_cnt>0): discarded; drop_cnt -= 1.
- Stall:
  - io_stall_en blocks only new requests.
  - Outstanding responses still enqueue; the queue still drains.
  - Redirects are still honoured during stall.
- Outputs io_out_pc/io_out_inst are don't-care when io_out_valid=0.
- Arithmetic:
  - All additions are XLEN-bit, wrap modulo 2^XLEN.
  - Counters are sized log2(QDEPTH)+1.

Test Plan:
1. Reset release, memory ready=1, 1-cycle response, out_ready=1 → requests at 0x0,0x4,0x8…; io_out_pc sequence 0x0,0x4,0x8 with matching inst; io_misaligned=0.
2. out_ready=0, memory always ready, QDEPTH=4 → exactly 4 requests accepted, then req_valid=0; out_ready=1 → pops 0x0..0xC in order and fetching resumes at 0x10.
3. Memory latency 3 cycles, 2 requests outstanding, io_jal_en with br_pc=0x8, imm=0x100 → both stale responses dropped; next request addr 0x108; first io_out_pc=0x108.
4. io_jalr_en with rs1=0x201, imm=0x4 → target 0x204 (bit0 cleared); simultaneous io_jal_en with br_pc=0x0, imm=0x40 → target 0x40 (JAL priority).
5. io_jalr_en with rs1=0x102, imm=0 → io_misaligned=1, req_valid stays 0 indefinitely, io_out_valid=0; reset clears it and fetching restarts at RESET_VECTOR.
6. XLEN=32, RESET_VECTOR=0xFFFFFFF8, io_stall_en pulsed 5 cycles mid-stream → PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap); no requests during stall; no entries lost or duplicated.
